wb_data_arbiter: RTL and testbench
==================================

// Module: wb_data_arbiter
// PURPOSE
//  Round-robin arbiter sharing one Wishbone-style data slave (RAM/IO) among
//  NUM_CPU j1 cores. Each core's data port (cyc/we/adr/dat_o, dat_i/ack_i)
//  connects to one requester slot. Exactly one core owns the slave per
//  transfer. Instruction fetch and UART paths are not routed here.
// PARAMETERS
//  NUM_CPU  4   number of requester slots (2..8)
//  DATA_W   32  data width
//  ADR_W    32  address width
//  CNT_W    8   timeout counter width (used only with ARB_TIMEOUT_EN)
// PORTS
//  clk        in   1               system clock, rising edge
//  rst        in   1               asynchronous, active-low reset
//  s_cyc_i    in   NUM_CPU         per-core request (core k = bit k)
//  s_we_i     in   NUM_CPU         per-core write enable
//  s_adr_i    in   NUM_CPU*ADR_W   per-core address, core k at [k*ADR_W +: ADR_W]
//  s_dat_i    in   NUM_CPU*DATA_W  per-core write data
//  s_ack_o    out  NUM_CPU         per-core acknowledge
//  s_dat_o    out  DATA_W          read data, broadcast to all cores
//  m_cyc_o    out  1               slave cycle
//  m_we_o     out  1               slave write enable
//  m_adr_o    out  ADR_W           slave address
//  m_dat_o    out  DATA_W          slave write data
//  m_dat_i    in   DATA_W          slave read data
//  m_ack_i    in   1               slave acknowledge
//  grant_o    out  NUM_CPU         one-hot current owner; 0 when idle
// BEHAVIOUR
//  - Reset (rst=0, async): state=IDLE, grant_o=0, priority pointer=0,
//    m_cyc_o=0, m_we_o=0, m_adr_o=0, m_dat_o=0, s_ack_o=0.
//  - States: IDLE, BUSY.
//  - IDLE: if s_cyc_i!=0, pick the first set bit starting at pointer ptr and
//    searching upward mod NUM_CPU. Register grant_o=onehot(winner) and go to
//    BUSY on the next edge. m_cyc_o rises 1 cycle after the request is seen.
//  - BUSY: m_cyc_o=1. m_we_o, m_adr_o, m_dat_o are a combinational mux of
//    the granted slot, so a core may change adr/dat while waiting.
//  - s_ack_o = grant_o & {NUM_CPU{m_ack_i & BUSY}}. This is a combinational
//    pass-through: zero added ack latency. Other cores' ack stays 0.
//  - s_dat_o = m_dat_i at all times, unregistered.
//  - On the m_ack_i edge in BUSY: go to IDLE, grant_o=0, ptr=winner+1 mod
//    NUM_CPU. The next grant needs 1 IDLE cycle, so consecutive transfers
//    cost 1 dead cycle minimum.
//  - Owner drops s_cyc_i in BUSY without an ack (abort): go to IDLE on the
//    next edge, and ptr advances as on ack. m_cyc_o follows
//    s_cyc_i[owner] combinationally, so the slave sees the drop in the
//    same cycle.
//  - New requests arriving in BUSY are held off (ack=0). Cores keep cyc
//    asserted, so there is no loss.
//  - m_ack_i while IDLE is ignored: no s_ack_o, no state change.
//  - Fairness: a core waiting with cyc held is granted within NUM_CPU-1
//    other transfers.
//  - Async reset mid-transfer: outputs drop immediately, and the slave
//    cycle is abandoned.
// CONFIGURATION
//  ARB_TIMEOUT_EN defined: a CNT_W-bit counter clears on grant and
//    increments each BUSY cycle without m_ack_i. When it reaches
//    {CNT_W{1'b1}}, the block pulses s_ack_o for the owner for 1 cycle and
//    drives s_dat_o=32'hDEAD_BEEF (truncated to DATA_W) in that cycle. It
//    then goes to IDLE and advances ptr, so a dead slave cannot hang a core.
//  ARB_TIMEOUT_EN undefined: no counter exists, and BUSY waits for
//    m_ack_i indefinitely.
// TESTING
//  1 Reset: hold rst=0 with random inputs -> all outputs 0. Release, with
//    s_cyc_i=0 -> stays IDLE.
//  2 Single read: core2 requests adr=0x100, we=0; slave acks 2 cycles after
//    m_cyc_o with dat=0x12345678 -> grant_o=0100 one cycle after the
//    request; s_ack_o=0100 for exactly 1 cycle; s_dat_o=0x12345678 in the
//    ack cycle.
//  3 Round-robin: s_cyc_i=1111 held, each slave ack immediate -> grant
//    order 0,1,2,3,0 with 1 dead cycle between grants.
//  4 Write mux: core1 we=1, adr=0x40, dat=0xA5A5A5A5, core3 also
//    requesting -> while core1 is owner, m_we_o=1, m_adr_o=0x40,
//    m_dat_o=0xA5A5A5A5; core3 sees no ack until core1's ack.
//  5 Abort/stray ack: owner drops cyc before ack -> IDLE next cycle, ptr
//    advanced. m_ack_i pulsed in IDLE -> s_ack_o stays 0.
//  6 ARB_TIMEOUT_EN, CNT_W=4, slave never acks -> s_ack_o pulses to the
//    owner after 15 BUSY cycles with s_dat_o=0xDEADBEEF. Without the macro
//    -> BUSY persists >100 cycles.

Source files
------------

// File: rtl/wb_data_arbiter_if.sv
// Bus bundle for wb_data_arbiter: per-core data-port requester slots plus the
// shared Wishbone-style slave port and the current-owner indication.
`timescale 1ns/1ps
interface wb_data_arbiter_if #(
    parameter int unsigned NUM_CPU = 4,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned ADR_W   = 32
);
    logic [NUM_CPU-1:0]        s_cyc_i;
    logic [NUM_CPU-1:0]        s_we_i;
    logic [NUM_CPU*ADR_W-1:0]  s_adr_i;
    logic [NUM_CPU*DATA_W-1:0] s_dat_i;
    logic [NUM_CPU-1:0]        s_ack_o;
    logic [DATA_W-1:0]         s_dat_o;
    logic                      m_cyc_o;
    logic                      m_we_o;
    logic [ADR_W-1:0]          m_adr_o;
    logic [DATA_W-1:0]         m_dat_o;
    logic [DATA_W-1:0]         m_dat_i;
    logic                      m_ack_i;
    logic [NUM_CPU-1:0]        grant_o;

    // Arbiter view
    modport slave (
        input  s_cyc_i, s_we_i, s_adr_i, s_dat_i, m_dat_i, m_ack_i,
        output s_ack_o, s_dat_o, m_cyc_o, m_we_o, m_adr_o, m_dat_o, grant_o
    );

    // Environment view: the cores and the shared data slave
    modport master (
        output s_cyc_i, s_we_i, s_adr_i, s_dat_i, m_dat_i, m_ack_i,
        input  s_ack_o, s_dat_o, m_cyc_o, m_we_o, m_adr_o, m_dat_o, grant_o
    );
endinterface

// File: rtl/wb_data_arbiter.sv
// Round-robin arbiter giving NUM_CPU j1 data ports shared access to one slave.
// Define ARB_TIMEOUT_EN to force-complete transfers the slave never acknowledges.
`timescale 1ns/1ps
module wb_data_arbiter #(
    parameter int unsigned NUM_CPU = 4,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned ADR_W   = 32,
    parameter int unsigned CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    wb_data_arbiter_if.slave bus
);
    localparam int unsigned PTR_W = $clog2(NUM_CPU);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t             state_q, state_d;
    logic [PTR_W-1:0]   owner_q, owner_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [PTR_W-1:0]   next_ptr, win, cand;
    logic [NUM_CPU-1:0] grant;
    logic               busy, found, owner_cyc, timeout;

    assign busy     = (state_q == BUSY);
    assign grant    = busy ? (NUM_CPU'(1) << owner_q) : '0;
    assign next_ptr = (owner_q == PTR_W'(NUM_CPU - 1)) ? '0 : owner_q + PTR_W'(1);

    // First requester at or above the pointer, wrapping round
    always_comb begin
        found = 1'b0;
        win   = ptr_q;
        cand  = '0;
        for (int unsigned i = 0; i < NUM_CPU; i++) begin
            cand = PTR_W'((32'(ptr_q) + i) % NUM_CPU);
            if (!found && bus.s_cyc_i[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        unique case (state_q)
            IDLE: begin
                if (found) begin
                    state_d = BUSY;
                    owner_d = win;
                end
            end
            BUSY: begin
                if (bus.m_ack_i || timeout || !owner_cyc) begin
                    state_d = IDLE;
                    ptr_d   = next_ptr;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            owner_q <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
        end
    end

    // Live mux of the owner's port; cyc follows the owner so an abort reaches the slave at once
    always_comb begin
        owner_cyc   = 1'b0;
        bus.m_we_o  = 1'b0;
        bus.m_adr_o = '0;
        bus.m_dat_o = '0;
        for (int unsigned k = 0; k < NUM_CPU; k++) begin
            if (grant[k]) begin
                owner_cyc   = bus.s_cyc_i[k];
                bus.m_we_o  = bus.s_we_i[k];
                bus.m_adr_o = bus.s_adr_i[k*ADR_W +: ADR_W];
                bus.m_dat_o = bus.s_dat_i[k*DATA_W +: DATA_W];
            end
        end
    end

    assign bus.m_cyc_o = owner_cyc;
    assign bus.grant_o = grant;
    assign bus.s_ack_o = grant & {NUM_CPU{bus.m_ack_i | timeout}};

`ifdef ARB_TIMEOUT_EN
    localparam logic [DATA_W-1:0] TMO_DATA = DATA_W'(32'hDEAD_BEEF);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Held at zero while idle, so every grant starts a fresh count
    assign timeout = busy && !bus.m_ack_i && (cnt_q == '1);

    always_comb begin
        cnt_d = cnt_q;
        if (!busy)
            cnt_d = '0;
        else if (!bus.m_ack_i)
            cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign bus.s_dat_o = timeout ? TMO_DATA : bus.m_dat_i;
`else
    assign timeout     = 1'b0;
    assign bus.s_dat_o = bus.m_dat_i;
`endif
endmodule

// File: tb/tb_wb_data_arbiter.sv
// Self-checking bench for wb_data_arbiter: directed scenarios plus random traffic
// compared every cycle against a transaction-level round-robin model.
`timescale 1ns/1ps
module tb_wb_data_arbiter;
    localparam int unsigned N  = 4;
    localparam int unsigned DW = 32;
    localparam int unsigned AW = 32;
    localparam int unsigned CW = 4;
`ifdef ARB_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    wb_data_arbiter_if #(.NUM_CPU(N), .DATA_W(DW), .ADR_W(AW)) bus ();

    wb_data_arbiter #(.NUM_CPU(N), .DATA_W(DW), .ADR_W(AW), .CNT_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Stimulus staging
    logic [N-1:0]         cyc, we;
    logic [N-1:0][AW-1:0] adr;
    logic [N-1:0][DW-1:0] dat;
    logic                 mack;
    logic [DW-1:0]        mdat;

    // Reference model: who owns the slave, whose turn is next, how long it has waited
    bit          m_busy;
    int unsigned m_own, m_ptr, m_cnt;

    int unsigned total = 0;
    int unsigned bad   = 0;

    logic [N-1:0] t3_exp [10] = '{4'b0000, 4'b0001, 4'b0000, 4'b0010, 4'b0000,
                                  4'b0100, 4'b0000, 4'b1000, 4'b0000, 4'b0001};

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic apply();
        bus.s_cyc_i = cyc;
        bus.s_we_i  = we;
        bus.s_adr_i = adr;
        bus.s_dat_i = dat;
        bus.m_ack_i = mack;
        bus.m_dat_i = mdat;
    endtask

    task automatic model_reset();
        m_busy = 1'b0;
        m_own  = 0;
        m_ptr  = 0;
        m_cnt  = 0;
    endtask

    task automatic rand_inputs();
        cyc = N'($urandom);
        we  = N'($urandom);
        for (int k = 0; k < N; k++) begin
            adr[k] = $urandom;
            dat[k] = $urandom;
        end
        mack = 1'($urandom);
        mdat = $urandom;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, ".grant"}, 32'(bus.grant_o), 0);
        check_eq({tag, ".m_cyc"}, 32'(bus.m_cyc_o), 0);
        check_eq({tag, ".m_we"},  32'(bus.m_we_o), 0);
        check_eq({tag, ".m_adr"}, bus.m_adr_o, 0);
        check_eq({tag, ".m_dat"}, bus.m_dat_o, 0);
        check_eq({tag, ".s_ack"}, 32'(bus.s_ack_o), 0);
        check_eq({tag, ".s_dat"}, bus.s_dat_o, bus.m_dat_i);
    endtask

    // Asynchronous assertion between edges, random inputs while held, release with no requests
    task automatic do_reset(input int unsigned hold);
        @(negedge clk);
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        check_reset_outputs("rst.async");
        for (int i = 0; i < int'(hold); i++) begin
            @(negedge clk);
            rand_inputs();
            apply();
            #1;
            check_reset_outputs("rst.hold");
        end
        @(negedge clk);
        cyc  = '0;
        we   = '0;
        mack = 1'b0;
        apply();
        rst = 1'b1;
    endtask

    // One clock: drive, compare against the model, then advance the model past the edge
    task automatic cycle(input string tag);
        bit              tmo;
        logic [N-1:0]    eg;
        logic            ecyc, ewe;
        logic [AW-1:0]   eadr;
        logic [DW-1:0]   edat;
        @(negedge clk);
        apply();
        #1;
        tmo  = TMO_EN && m_busy && !mack && (m_cnt == (1 << CW) - 1);
        eg   = '0;
        ecyc = 1'b0;
        ewe  = 1'b0;
        eadr = '0;
        edat = '0;
        if (m_busy) begin
            eg[m_own] = 1'b1;
            ecyc = cyc[m_own];
            ewe  = we[m_own];
            eadr = adr[m_own];
            edat = dat[m_own];
        end
        check_eq({tag, ".grant"}, 32'(bus.grant_o), 32'(eg));
        check_eq({tag, ".m_cyc"}, 32'(bus.m_cyc_o), 32'(ecyc));
        check_eq({tag, ".m_we"},  32'(bus.m_we_o), 32'(ewe));
        check_eq({tag, ".m_adr"}, bus.m_adr_o, eadr);
        check_eq({tag, ".m_dat"}, bus.m_dat_o, edat);
        check_eq({tag, ".s_ack"}, 32'(bus.s_ack_o), (m_busy && (mack || tmo)) ? 32'(eg) : 0);
        check_eq({tag, ".s_dat"}, bus.s_dat_o, tmo ? 32'hDEAD_BEEF : mdat);
        if (m_busy) begin
            if (mack || tmo || !cyc[m_own]) begin
                m_busy = 1'b0;
                m_ptr  = (m_own + 1) % N;
            end else begin
                m_cnt++;
            end
        end else if (cyc != '0) begin
            for (int i = 0; i < N; i++) begin
                int unsigned c;
                c = (m_ptr + i) % N;
                if (cyc[c]) begin
                    m_own = c;
                    break;
                end
            end
            m_busy = 1'b1;
            m_cnt  = 0;
        end
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        cyc  = '0;
        we   = '0;
        adr  = '0;
        dat  = '0;
        mack = 1'b0;
        mdat = '0;
        apply();
        model_reset();

        // Reset, then idle with no requests
        do_reset(4);
        repeat (3) cycle("t1.idle");

        // Single read by core 2
        cyc = 4'b0100; we = '0; adr[2] = 32'h100;
        cycle("t2.req");
        check_eq("t2.grant_req", 32'(bus.grant_o), 0);
        cycle("t2.b0");
        check_eq("t2.grant", 32'(bus.grant_o), 32'h4);
        check_eq("t2.adr", bus.m_adr_o, 32'h100);
        cycle("t2.b1");
        mack = 1'b1; mdat = 32'h1234_5678;
        cycle("t2.ack");
        check_eq("t2.s_ack", 32'(bus.s_ack_o), 32'h4);
        check_eq("t2.s_dat", bus.s_dat_o, 32'h1234_5678);
        mack = 1'b0; cyc = '0;
        cycle("t2.after");
        check_eq("t2.ack_once", 32'(bus.s_ack_o), 0);

        // Round-robin with everyone requesting and immediate acks
        do_reset(2);
        cyc = 4'b1111; mack = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cycle("t3.rr");
            check_eq("t3.order", 32'(bus.grant_o), 32'(t3_exp[i]));
        end
        cyc = '0; mack = 1'b0;
        cycle("t3.end");

        // Write mux while core 3 waits
        do_reset(2);
        cyc = 4'b1010; we = 4'b0010;
        adr[1] = 32'h40; dat[1] = 32'hA5A5_A5A5;
        adr[3] = 32'h80; dat[3] = 32'h5A5A_5A5A;
        cycle("t4.req");
        cycle("t4.own1");
        check_eq("t4.we", 32'(bus.m_we_o), 1);
        check_eq("t4.adr", bus.m_adr_o, 32'h40);
        check_eq("t4.dat", bus.m_dat_o, 32'hA5A5_A5A5);
        check_eq("t4.core3_held", 32'(bus.s_ack_o), 0);
        adr[1] = 32'h44;
        cycle("t4.live");
        check_eq("t4.adr_live", bus.m_adr_o, 32'h44);
        mack = 1'b1;
        cycle("t4.ack1");
        check_eq("t4.s_ack1", 32'(bus.s_ack_o), 32'h2);
        mack = 1'b0; cyc = 4'b1000;
        cycle("t4.dead");
        check_eq("t4.dead_grant", 32'(bus.grant_o), 0);
        cycle("t4.own3");
        check_eq("t4.grant3", 32'(bus.grant_o), 32'h8);
        mack = 1'b1;
        cycle("t4.ack3");
        mack = 1'b0; cyc = '0; we = '0;
        cycle("t4.end");

        // Abort advances the pointer; stray ack in idle is ignored
        do_reset(2);
        cyc = 4'b0001;
        cycle("t5.req");
        cycle("t5.own0");
        cyc = 4'b0000;
        cycle("t5.abort");
        check_eq("t5.m_cyc_drop", 32'(bus.m_cyc_o), 0);
        cyc = 4'b0011;
        cycle("t5.idle");
        check_eq("t5.idle_grant", 32'(bus.grant_o), 0);
        cycle("t5.next");
        check_eq("t5.ptr_adv", 32'(bus.grant_o), 32'h2);
        mack = 1'b1;
        cycle("t5.ack");
        cyc = '0; mack = 1'b0;
        cycle("t5.gap");
        mack = 1'b1;
        cycle("t5.stray");
        check_eq("t5.stray_ack", 32'(bus.s_ack_o), 0);
        mack = 1'b0;
        cycle("t5.after");
        check_eq("t5.stray_state", 32'(bus.grant_o), 0);

        // Reset in the middle of a transfer
        do_reset(1);
        cyc = 4'b0100;
        cycle("t7.req");
        cycle("t7.busy");
        check_eq("t7.m_cyc_up", 32'(bus.m_cyc_o), 1);
        do_reset(1);
        cycle("t7.after");

        // Slave that never acknowledges
        do_reset(1);
        cyc = 4'b0001; mack = 1'b0;
        cycle("t6.req");
`ifdef ARB_TIMEOUT_EN
        begin
            int unsigned n;
            n = 0;
            for (int i = 1; i <= 40; i++) begin
                cycle("t6.wait");
                if (bus.s_ack_o != '0) begin
                    n = i;
                    break;
                end
            end
            check_eq("t6.tmo_cycle", n, 16);
            check_eq("t6.tmo_ack", 32'(bus.s_ack_o), 32'h1);
            check_eq("t6.tmo_dat", bus.s_dat_o, 32'hDEAD_BEEF);
        end
`else
        repeat (110) cycle("t6.wait");
        check_eq("t6.still_busy", 32'(bus.grant_o), 32'h1);
        check_eq("t6.still_cyc", 32'(bus.m_cyc_o), 1);
`endif
        cyc = '0;
        cycle("t6.end");

        // Random traffic; periodic stretches of silence from the slave
        cyc = '0;
        for (int n = 0; n < 3000; n++) begin
            bit quiet;
            quiet = (n % 300) >= 240;
            for (int k = 0; k < N; k++)
                if ($urandom_range(0, quiet ? 31 : 7) == 0) cyc[k] = ~cyc[k];
            we = N'($urandom);
            for (int k = 0; k < N; k++) begin
                if ($urandom_range(0, 3) == 0) adr[k] = $urandom;
                if ($urandom_range(0, 3) == 0) dat[k] = $urandom;
            end
            mack = !quiet && ($urandom_range(0, 2) == 0);
            mdat = $urandom;
            cycle("rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
